// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// ------------
// 8N1 UART receiver with a single-entry output register and valid/ready handoff.
// The serial input is synchronised into the clk domain, and each bit is sampled
// near its centre using a 16x oversample tick. A received byte is offered on
// Dout/valid until the consumer takes it with valid&ready. A bad stop bit
// produces a frame_err pulse. A byte that arrives while the output register is
// still full produces an overrun pulse and is dropped.
//
// Parameters
//   CLK_DIV    clk cycles per oversample tick (16 ticks per bit), 2..1023
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous, active-low reset
//   Din        serial line, idle high, asynchronous to clk
//   rx_en      enables detection of a new start bit
//   Dout       received byte, LSB is the first data bit on the line
//   valid      Dout holds a byte that has not been consumed yet
//   ready      consumer takes Dout when valid&ready at a clk edge
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: byte dropped because Dout was still full
//   busy       high whenever the receiver is not idle
module uart_rx_ctrl #(
  parameter int CLK_DIV = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  input  logic       rx_en,
  output logic [7:0] Dout,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // The largest legal divider is 1023, so a 10-bit counter always fits.
  localparam logic [9:0] DIV_MAX = 10'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        line_prev_q, line_prev_d;
  logic [9:0]  div_cnt_q, div_cnt_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;

  logic        line;
  logic        fall_edge;
  logic        tick;
  logic        mid_start;
  logic        bit_end;

  assign line      = sync2_q;
  // The previous-line flop resets high, so after reset only a genuine
  // high-to-low transition of the synchronised line can start a frame.
  // It also keeps a held-low break from retriggering after a bad frame.
  assign fall_edge = line_prev_q & ~line;
  // The tick counter is held at zero while idle, so tick never fires there.
  assign tick      = (state_q != IDLE) && (div_cnt_q == DIV_MAX);
  // The 8th tick after the start edge lands mid-start-bit; after that,
  // every 16th tick lands mid-bit.
  assign mid_start = tick && (samp_cnt_q == 4'd7);
  assign bit_end   = tick && (samp_cnt_q == 4'd15);

  // Next-state and datapath logic. The flag pulses default low so they
  // can only be high for the one cycle after the stop sample that set them.
  always_comb begin
    state_d     = state_q;
    sync1_d     = Din;
    sync2_d     = sync1_q;
    line_prev_d = sync2_q;
    div_cnt_d   = div_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (state_q == IDLE) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d  = '0;
      samp_cnt_d = samp_cnt_q + 4'd1;
    end else begin
      div_cnt_d = div_cnt_q + 10'd1;
    end

    // A consume clears valid unless the stop sample below reloads it
    // in the same cycle.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        samp_cnt_d = '0;
        if (rx_en && fall_edge) begin
          state_d    = START;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
        end
      end

      START: begin
        if (mid_start) begin
          if (!line) begin
            state_d    = DATA;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            // The line went back high before mid-start-bit, so this was a glitch.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (bit_end) begin
          // Shifting right with the new bit at the top leaves the first bit
          // in bit 0 after eight samples.
          shift_d   = {line, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!line) begin
            frame_err_d = 1'b1;
          end else if (!valid_q || ready) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state registers. The synchroniser and edge flops reset to the
  // idle-line level so that reset release cannot look like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign Dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 54, giving clk cycles per oversample tick (16 ticks per bit); legal range 2..1023.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low; one clock domain only.
REQ-004 SHALL have port Din  input  1  serial line; idle high; asynchronous to clk.
REQ-005 SHALL have port rx_en  input  1  allows start detection when high.
REQ-006 SHALL have port Dout  output  8  received byte; LSB is the first data bit received.
REQ-007 SHALL have port valid  output  1  Dout holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts Dout when valid&ready at posedge clk.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: byte dropped because the output register was full.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL pass Din through a 2-flop synchronizer (both flops reset to 1); "line" below means the synchronized value.
REQ-013 SHALL generate tick from a counter 0..CLK_DIV-1; tick is high for one clk when count==CLK_DIV-1; counter held at 0 in IDLE.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; encoding is free.
REQ-015 IDLE -> START SHALL occur on a falling edge of line (previous 1, current 0) while rx_en=1; tick counter and 4-bit sample counter cleared.
REQ-016 START SHALL sample line on the 8th tick; 0 -> DATA with sample and bit counters cleared; 1 -> IDLE (glitch rejected, no flags, no output).
REQ-017 DATA SHALL sample line on every 16th tick and shift it in LSB-first; after the 8th bit -> STOP.
REQ-018 STOP SHALL sample line on the 16th tick and always return to IDLE in the next cycle.
REQ-019 Stop sample 0 SHALL pulse frame_err for one clk and discard the byte; Dout and valid are unchanged.
REQ-020 Stop sample 1 with valid=0, or with valid=1 and ready=1 in the same cycle, SHALL load Dout and hold valid=1 from the next clk.
REQ-021 Stop sample 1 with valid=1 and ready=0 SHALL pulse overrun for one clk, drop the new byte and leave Dout unchanged.
REQ-022 valid SHALL clear on the clk after valid&ready, unless a load occurs in that same cycle.
REQ-023 Dout SHALL remain stable while valid=1 and ready=0.
REQ-024 Dropping rx_en mid-frame SHALL NOT abort the frame; only new start detection is blocked.
REQ-025 A held-low line (break) after a frame error SHALL NOT retrigger START until a new high-to-low edge occurs.
REQ-026 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-027 rst=0 SHALL immediately force: state IDLE, all counters 0, shift register 0, Dout=8'h00, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no output and no flag pulse.
REQ-029 After rst rises, the first byte SHALL be accepted only on a fresh falling edge of line.

Verification (CLK_DIV=4, i.e. 64 clk per bit)
REQ-030 Frame 0x5A, correct stop bit, ready=0 -> Dout=8'h5A, valid=1 within 2 clk after the stop sample, frame_err=0.
REQ-031 Low glitch of 20 clk on an idle line -> returns to IDLE at the start sample, valid=0, no flags, busy low again.
REQ-032 Frame 0xC3 with stop bit driven 0 -> single-cycle frame_err, valid stays 0; line held low afterwards -> no new START.
REQ-033 Two frames 0x11 then 0x22 with ready=0 throughout -> Dout=8'h11, valid=1, one overrun pulse at the second stop sample.
REQ-034 Same as REQ-033 but ready=1 exactly on the second stop-sample cycle -> 0x11 consumed, Dout=8'h22, valid=1, no overrun.
REQ-035 rst pulsed low during bit 4 of a frame, then frame 0xA5 -> all outputs at reset values immediately; subsequent Dout=8'hA5, valid=1.
